// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transfer sequencer.
package uart_pkg;

    localparam int unsigned UART_WORD_SIZE = 262144;
    localparam int unsigned UART_ADDR_W    = 28;

    localparam logic [2:0] WR_SEL_IDLE = 3'd0;
    localparam logic [2:0] WR_SEL_RX   = 3'd1;
    localparam logic [2:0] WR_SEL_TX   = 3'd2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        RX_WAIT = 3'd2,
        RX_BUS  = 3'd3,
        TX_BUS  = 3'd4,
        TX_WAIT = 3'd5,
        DONE    = 3'd6
    } xfer_state_e;

endpackage

// File: rtl/uart_xfer_sched_if.sv
// Control/status bundle between sys_state_ctrl, uart_unit and the transfer sequencer.
interface uart_xfer_sched_if #(
    parameter int unsigned CNT_W  = 19,
    parameter int unsigned ADDR_W = 28
);
    logic              start;
    logic              dir;
    logic              abort;
    logic [ADDR_W-1:0] cfg_base;
    logic [CNT_W-1:0]  cfg_len;
    logic              rxd_ready;
    logic              txd_valid;
    logic              bus_done;
    logic              uart_en;
    logic [2:0]        wr_sel;
    logic              link_write;
    logic              link_read;
    logic [ADDR_W-1:0] init_addr;
    logic              init_addr_en;
    logic              busy;
    logic [CNT_W-1:0]  word_cnt;
    logic              wdone;
    logic              rdone;
    logic              err;

    modport master (
        output start, dir, abort, cfg_base, cfg_len, rxd_ready, txd_valid, bus_done,
        input  uart_en, wr_sel, link_write, link_read, init_addr, init_addr_en,
               busy, word_cnt, wdone, rdone, err
    );

    modport slave (
        input  start, dir, abort, cfg_base, cfg_len, rxd_ready, txd_valid, bus_done,
        output uart_en, wr_sel, link_write, link_read, init_addr, init_addr_en,
               busy, word_cnt, wdone, rdone, err
    );
endinterface

// File: rtl/uart_xfer_cnt.sv
// Word counter for one transfer: clamps the requested length and flags the last word.
module uart_xfer_cnt #(
    parameter int unsigned WORD_SIZE = 262144,
    parameter int unsigned CNT_W     = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             inc,
    output logic [CNT_W-1:0] word_cnt,
    output logic             last,
    output logic             len_zero
);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(WORD_SIZE);

    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        len_d = len_q;
        cnt_d = cnt_q;
        if (load) begin
            len_d = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            cnt_q <= '0;
        end else begin
            len_q <= len_d;
            cnt_q <= cnt_d;
        end
    end

    assign word_cnt = cnt_q;
    assign last     = (cnt_q + CNT_W'(1)) == len_q;
    assign len_zero = (len_q == '0);

endmodule

// File: rtl/uart_xfer_sched.sv
// UART transfer sequencer: one receive or send transfer at a time, word-counted.
// Optional per-word idle timeout is enabled by defining XFER_TIMEOUT_EN.
module uart_xfer_sched
    import uart_pkg::*;
#(
    parameter int unsigned WORD_SIZE = UART_WORD_SIZE,
    parameter int unsigned CNT_W     = $clog2(WORD_SIZE + 1),
    parameter int unsigned ADDR_W    = UART_ADDR_W,
    parameter int unsigned TIMEOUT   = 1048576
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_xfer_sched_if.slave   bus
);
    xfer_state_e       state_q, state_d;
    logic              dir_q, dir_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              err_q, err_d;
    logic              cnt_load, cnt_inc;
    logic              cnt_last, cnt_len_zero;
    logic [CNT_W-1:0]  cnt_val;
    logic              tmo_hit;

    uart_xfer_cnt #(
        .WORD_SIZE (WORD_SIZE),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .cfg_len  (bus.cfg_len),
        .inc      (cnt_inc),
        .word_cnt (cnt_val),
        .last     (cnt_last),
        .len_zero (cnt_len_zero)
    );

`ifdef XFER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             in_wait;

    assign in_wait = (state_q == RX_WAIT) || (state_q == RX_BUS) ||
                     (state_q == TX_BUS)  || (state_q == TX_WAIT);
    // Fires on the TIMEOUT-th cycle spent in the same wait state.
    assign tmo_hit = in_wait && (tmo_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        tmo_d = tmo_q + TMO_W'(1);
        if (state_d != state_q || !in_wait) tmo_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        base_d   = base_q;
        err_d    = err_q;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d  = INIT;
                    dir_d    = bus.dir;
                    base_d   = bus.cfg_base;
                    err_d    = 1'b0;
                    cnt_load = 1'b1;
                end
            end
            INIT: begin
                if (cnt_len_zero) state_d = DONE;
                else if (dir_q)   state_d = TX_BUS;
                else              state_d = RX_WAIT;
            end
            RX_WAIT: begin
                if (bus.rxd_ready) state_d = RX_BUS;
            end
            RX_BUS: begin
                // A second received word before the bus beat completes is lost.
                if (bus.rxd_ready) err_d = 1'b1;
                if (bus.bus_done) begin
                    cnt_inc = 1'b1;
                    state_d = cnt_last ? DONE : RX_WAIT;
                end
            end
            TX_BUS: begin
                if (bus.bus_done) state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (bus.txd_valid) begin
                    cnt_inc = 1'b1;
                    state_d = cnt_last ? DONE : TX_BUS;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
            cnt_inc = 1'b0;
            err_d   = err_q;
        end else if (tmo_hit) begin
            state_d = IDLE;
            cnt_inc = 1'b0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            base_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            base_q  <= base_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.uart_en      = (state_q != IDLE);
    assign bus.wr_sel       = (state_q == IDLE) ? WR_SEL_IDLE : (dir_q ? WR_SEL_TX : WR_SEL_RX);
    assign bus.link_write   = (state_q == RX_BUS);
    assign bus.link_read    = (state_q == TX_BUS);
    assign bus.init_addr_en = (state_q == INIT);
    assign bus.init_addr    = (state_q == INIT) ? base_q : '0;
    assign bus.word_cnt     = cnt_val;
    assign bus.wdone        = (state_q == DONE) && !dir_q;
    assign bus.rdone        = (state_q == DONE) && dir_q;
    assign bus.err          = err_q;

endmodule

// File: doc/uart_xfer_sched.md
Name: uart_xfer_sched

Overview:
Sequencer for the UART unit. Owns uart_en, UnUc_wr_sel, link_write/link_read and the bridge start address, and counts 32-bit words moved between UART and memory. Provides the IO-complete flags (rdone/wdone) and an error flag to the system state controller. Sits between sys_state_ctrl and uart_unit; one transfer at a time, direction chosen per transfer.

Parameters:
WORD_SIZE, 262144, maximum words per transfer (64x64 image, 64 channels)
CNT_W, 19, word-counter width, $clog2(WORD_SIZE+1)
ADDR_W, 28, bus address width
TIMEOUT, 1048576, idle-cycle limit per word (only with XFER_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle transfer request; sampled only in IDLE
dir  in  1  0 = UART->memory (receive), 1 = memory->UART (send); sampled with start
abort  in  1  cancel the current transfer
cfg_base  in  ADDR_W  first word address; sampled with start
cfg_len  in  CNT_W  word count; sampled with start
rxd_ready  in  1  pulse: UART has a complete 32-bit received word
txd_valid  in  1  pulse: UART finished shifting out the current word
bus_done  in  1  pulse: bridge completed the bus beat for the current word
uart_en  out  1  UART clock enable
wr_sel  out  3  UnUc_wr_sel: 0 idle, 1 receive, 2 send
link_write  out  1  unit drives bus (receive path)
link_read  out  1  unit samples bus (send path)
init_addr  out  ADDR_W  UnUb_initAddr
init_addr_en  out  1  UnUb_initAddrEn, one-cycle pulse
busy  out  1  high in every state except IDLE
word_cnt  out  CNT_W  words completed in the current transfer
wdone  out  1  one-cycle pulse: receive transfer complete
rdone  out  1  one-cycle pulse: send transfer complete
err  out  1  sticky error, cleared by the next accepted start

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n). Reset forces IDLE; every output 0; word_cnt 0; err 0.
- All outputs are registered or decoded from the registered state. No combinational path from input to output.
- States: IDLE, INIT, RX_WAIT, RX_BUS, TX_BUS, TX_WAIT, DONE.
- IDLE: start=1 and abort=0 -> INIT. Latch dir, cfg_base, and len = min(cfg_len, WORD_SIZE). Clear word_cnt and err.
- INIT: lasts exactly 1 cycle. init_addr_en=1 and init_addr=latched base.
  - len==0 -> DONE.
  - Otherwise dir=0 -> RX_WAIT; dir=1 -> TX_BUS.
- RX_WAIT: wait for rxd_ready, then -> RX_BUS.
- RX_BUS: link_write=1. On bus_done, word_cnt++. If word_cnt+1==len -> DONE, else -> RX_WAIT.
- TX_BUS: link_read=1. On bus_done -> TX_WAIT.
- TX_WAIT: wait for txd_valid, then word_cnt++. If word_cnt+1==len -> DONE, else -> TX_BUS.
- DONE: lasts 1 cycle, then -> IDLE. Pulse wdone (dir=0) or rdone (dir=1). word_cnt holds its final value until the next start.
- Output decode in INIT through DONE: uart_en=1; wr_sel=1 if dir=0, else 2. In IDLE: uart_en=0, wr_sel=0.
- link_write and link_read are never high together.
- Latency: start seen in cycle n -> init_addr_en in cycle n+1. Last completing pulse in cycle m -> done pulse in cycle m+1.
- abort in any non-IDLE state -> IDLE next cycle. All links drop, no done pulse, word_cnt kept, err unchanged.
- abort and start together in IDLE -> abort wins; the block stays in IDLE.
- start while busy -> ignored.
- rxd_ready while in RX_BUS (overrun) -> err=1; the word is dropped and the transfer continues.
- bus_done, rxd_ready or txd_valid in a state that does not consume them -> ignored, except the overrun case above.

Optional Feature:
XFER_TIMEOUT_EN
- Defined: a per-word cycle counter, cleared on every state change. If it reaches TIMEOUT in RX_WAIT, RX_BUS, TX_BUS or TX_WAIT: set err, -> IDLE, no done pulse.
- Undefined: no counter and no timeout; the wait states can wait indefinitely.

Decomposition:
- Shared package uart_pkg holds:
  - enum xfer_state_e for the seven states;
  - constants WR_SEL_IDLE=3'd0, WR_SEL_RX=3'd1, WR_SEL_TX=3'd2;
  - WORD_SIZE default and ADDR_W.
- One natural sub-module, uart_xfer_cnt: word counter with len compare, clamp and last flag. The FSM stays in the top module.

Test Plan:
- Receive, 3 words: start, dir=0, base=0x100, len=3. Three rxd_ready/bus_done pairs -> init_addr=0x100 pulse 1 cycle after start; link_write high only in RX_BUS; word_cnt=3; wdone 1 cycle after the 3rd bus_done; rdone stays 0.
- Send, 2 words: dir=1, len=2; bus_done then txd_valid, twice -> link_read high in TX_BUS only; rdone after the 2nd txd_valid; wr_sel=2 throughout.
- Zero length: len=0 -> INIT then DONE; wdone pulses 2 cycles after start; no link asserted.
- Length clamp: len=WORD_SIZE+5 -> transfer ends at word_cnt=WORD_SIZE (check with WORD_SIZE=4 override).
- Abort and reset mid-transfer: abort after word 1 of 4 -> IDLE next cycle, word_cnt=1, no done. Assert rst_n=0 in RX_BUS -> all outputs 0 immediately.
- Overrun and timeout: rxd_ready during RX_BUS -> err=1 and the transfer still completes. With XFER_TIMEOUT_EN and TIMEOUT=16, no rxd_ready -> err=1 and IDLE after 16 cycles.
